// File: rtl/collision_scanner.sv
// rtl/collision_scanner.sv - per-frame time-multiplexed player/vehicle collision and progress checker
// Scans one vehicle slot per cycle after each frame tick, then resolves lives, grace, level and terminal state.
module collision_scanner #(
    parameter int NUM_CARS     = 12,
    parameter int X_W          = 8,
    parameter int Y_W          = 7,
    parameter int LEN_W        = 5,
    parameter int CAR_H        = 5,
    parameter int HUMAN_W      = 2,
    parameter int HUMAN_H      = 2,
    parameter int LIVES        = 3,
    parameter int GRACE_FRAMES = 60,
    parameter int LEVELS       = 2,
    parameter int GOAL_X       = 133,
    parameter int GOAL_Y_EVEN  = 102,
    parameter int GOAL_Y_ODD   = 21,
    localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1,
    localparam int LIV_W = $clog2(LIVES + 1),
    localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1,
    localparam int GR_W  = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      frame_tick,
    input  logic [X_W-1:0]            human_x,
    input  logic [Y_W-1:0]            human_y,
    input  logic [NUM_CARS*X_W-1:0]   car_x,
    input  logic [NUM_CARS*Y_W-1:0]   car_y,
    input  logic [NUM_CARS*LEN_W-1:0] car_len,
    input  logic [NUM_CARS-1:0]       car_active,
    output logic                      crushed,
    output logic [IDX_W-1:0]          hit_index,
    output logic [LIV_W-1:0]          lives,
    output logic [LVL_W-1:0]          level,
    output logic                      level_up,
    output logic                      game_over,
    output logic                      endgame,
    output logic                      busy,
    output logic                      overrun
);
    typedef enum logic [1:0] {S_IDLE, S_SNAP, S_SCAN, S_RESOLVE} state_t;

    state_t           r_state;
    logic [X_W-1:0]   r_hx;
    logic [Y_W-1:0]   r_hy;
    logic [IDX_W-1:0] r_idx;
    logic             r_hit;
    logic [IDX_W-1:0] r_first_idx;
    logic [GR_W-1:0]  r_grace;
    logic             r_crushed;
    logic [IDX_W-1:0] r_hit_index;
    logic [LIV_W-1:0] r_lives;
    logic [LVL_W-1:0] r_level;
    logic             r_level_up;
    logic             r_game_over;
    logic             r_endgame;
    logic             r_overrun;

    logic [X_W-1:0]   w_cx;
    logic [Y_W-1:0]   w_cy;
    logic [LEN_W-1:0] w_len;
    logic             w_act;
    logic [X_W:0]     w_cx_end;
    logic [X_W:0]     w_hx_end;
    logic [Y_W:0]     w_cy_end;
    logic [Y_W:0]     w_hy_end;
    logic             w_hit;
    logic [Y_W-1:0]   w_goal_y;
    logic             w_at_goal;

    always_comb begin
        w_cx  = '0;
        w_cy  = '0;
        w_len = '0;
        w_act = 1'b0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cx  = car_x[i*X_W +: X_W];
                w_cy  = car_y[i*Y_W +: Y_W];
                w_len = car_len[i*LEN_W +: LEN_W];
                w_act = car_active[i];
            end
        end
    end

    // One extra bit on every far edge so boxes near the screen limit do not wrap.
    assign w_cx_end = (X_W+1)'(w_cx) + (X_W+1)'(w_len);
    assign w_hx_end = (X_W+1)'(r_hx) + (X_W+1)'(HUMAN_W);
    assign w_cy_end = (Y_W+1)'(w_cy) + (Y_W+1)'(CAR_H);
    assign w_hy_end = (Y_W+1)'(r_hy) + (Y_W+1)'(HUMAN_H);
    assign w_hit = w_act && (w_len != '0)
                && ((X_W+1)'(r_hx) < w_cx_end) && ((X_W+1)'(w_cx) < w_hx_end)
                && ((Y_W+1)'(r_hy) < w_cy_end) && ((Y_W+1)'(w_cy) < w_hy_end);

    assign w_goal_y  = r_level[0] ? Y_W'(GOAL_Y_ODD) : Y_W'(GOAL_Y_EVEN);
    assign w_at_goal = (r_hx == X_W'(GOAL_X)) && (r_hy == w_goal_y);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hx        <= '0;
            r_hy        <= '0;
            r_idx       <= '0;
            r_hit       <= 1'b0;
            r_first_idx <= '0;
            r_grace     <= '0;
            r_crushed   <= 1'b0;
            r_hit_index <= '0;
            r_lives     <= LIV_W'(LIVES);
            r_level     <= '0;
            r_level_up  <= 1'b0;
            r_game_over <= 1'b0;
            r_endgame   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_crushed  <= 1'b0;
            r_level_up <= 1'b0;
            if (frame_tick && r_grace != '0)
                r_grace <= r_grace - GR_W'(1);
            if (frame_tick && r_state != S_IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (frame_tick && enable && !r_game_over && !r_endgame)
                        r_state <= S_SNAP;
                end
                S_SNAP: begin
                    r_hx    <= human_x;
                    r_hy    <= human_y;
                    r_hit   <= 1'b0;
                    r_idx   <= '0;
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    if (w_hit && !r_hit) begin
                        r_hit       <= 1'b1;
                        r_first_idx <= r_idx;
                    end
                    if (r_idx == IDX_W'(NUM_CARS - 1))
                        r_state <= S_RESOLVE;
                    else
                        r_idx <= r_idx + IDX_W'(1);
                end
                S_RESOLVE: begin
                    // The grace reload overrides a same-cycle tick decrement.
                    if (r_hit) begin
                        if (r_grace == '0) begin
                            r_lives     <= r_lives - LIV_W'(1);
                            r_crushed   <= 1'b1;
                            r_hit_index <= r_first_idx;
                            r_grace     <= GR_W'(GRACE_FRAMES);
                            if (r_lives == LIV_W'(1))
                                r_game_over <= 1'b1;
                        end
                    end else if (w_at_goal) begin
                        if (r_level != LVL_W'(LEVELS - 1)) begin
                            r_level    <= r_level + LVL_W'(1);
                            r_level_up <= 1'b1;
                        end else begin
                            r_endgame <= 1'b1;
                        end
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign crushed   = r_crushed;
    assign hit_index = r_hit_index;
    assign lives     = r_lives;
    assign level     = r_level;
    assign level_up  = r_level_up;
    assign game_over = r_game_over;
    assign endgame   = r_endgame;
    assign busy      = (r_state != S_IDLE);
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_collision_scanner.sv
// tb/tb_collision_scanner.sv - self-checking bench for collision_scanner
// A frame-level model predicts every output each cycle; directed scenarios pin it with literal values.
module tb_collision_scanner;
    localparam int NC = 12;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b1;
    logic             frame_tick = 1'b0;
    logic [7:0]       human_x = '0;
    logic [6:0]       human_y = '0;
    logic [NC*8-1:0]  car_x;
    logic [NC*7-1:0]  car_y;
    logic [NC*5-1:0]  car_len;
    logic [NC-1:0]    car_active;
    logic             crushed;
    logic [3:0]       hit_index;
    logic [1:0]       lives;
    logic [0:0]       level;
    logic             level_up;
    logic             game_over;
    logic             endgame;
    logic             busy;
    logic             overrun;

    int checks = 0;
    int errors = 0;

    int m_cx [NC];
    int m_cy [NC];
    int m_len[NC];
    bit m_act[NC];

    collision_scanner #(.NUM_CARS(NC)) dut (
        .clock(clock), .reset(reset), .enable(enable), .frame_tick(frame_tick),
        .human_x(human_x), .human_y(human_y), .car_x(car_x), .car_y(car_y),
        .car_len(car_len), .car_active(car_active), .crushed(crushed),
        .hit_index(hit_index), .lives(lives), .level(level), .level_up(level_up),
        .game_over(game_over), .endgame(endgame), .busy(busy), .overrun(overrun)
    );

    always #5 clock = ~clock;

    always_comb begin
        car_x = '0;
        car_y = '0;
        car_len = '0;
        car_active = '0;
        for (int i = 0; i < NC; i++) begin
            car_x[i*8 +: 8]   = 8'(m_cx[i]);
            car_y[i*7 +: 7]   = 7'(m_cy[i]);
            car_len[i*5 +: 5] = 5'(m_len[i]);
            car_active[i]     = m_act[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: a scan started by a tick on edge c0 snapshots the player on
    // edge c0+1 and applies its outcome on edge c0+NC+2.
    int m_cyc = 0, m_start = 0, m_grace = 0, m_lives = 3, m_level = 0, m_hidx = 0;
    int m_hx = 0, m_hy = 0;
    bit m_busy = 0, m_crushed = 0, m_level_up = 0, m_go = 0, m_eg = 0, m_overrun = 0;

    function automatic int first_hit(input int hx, input int hy);
        for (int i = 0; i < NC; i++)
            if (m_act[i] && m_len[i] != 0 && hx < m_cx[i] + m_len[i] && m_cx[i] < hx + 2
                && hy < m_cy[i] + 5 && m_cy[i] < hy + 2)
                return i;
        return -1;
    endfunction

    always @(posedge clock) begin
        int g_old, h;
        if (reset) begin
            m_busy = 0; m_crushed = 0; m_level_up = 0; m_go = 0; m_eg = 0; m_overrun = 0;
            m_grace = 0; m_lives = 3; m_level = 0; m_hidx = 0;
        end else begin
            m_crushed = 0;
            m_level_up = 0;
            g_old = m_grace;
            if (frame_tick) begin
                if (m_busy) m_overrun = 1;
                if (m_grace > 0) m_grace--;
            end
            if (m_busy) begin
                if (m_cyc == m_start + 1) begin
                    m_hx = int'(human_x);
                    m_hy = int'(human_y);
                end
                if (m_cyc == m_start + NC + 2) begin
                    m_busy = 0;
                    h = first_hit(m_hx, m_hy);
                    if (h >= 0) begin
                        if (g_old == 0) begin
                            m_lives--; m_crushed = 1; m_hidx = h; m_grace = 60;
                            if (m_lives == 0) m_go = 1;
                        end
                    end else if (m_hx == 133 && m_hy == ((m_level % 2 == 0) ? 102 : 21)) begin
                        if (m_level < 1) begin m_level++; m_level_up = 1; end
                        else m_eg = 1;
                    end
                end
            end else if (frame_tick && enable && !m_go && !m_eg) begin
                m_busy = 1;
                m_start = m_cyc;
            end
        end
        m_cyc++;
    end

    bit cmp_en = 0;
    int n_crush = 0, n_lvlup = 0;

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("crushed", 32'(crushed), 32'(m_crushed));
            chk("hit_index", 32'(hit_index), 32'(m_hidx));
            chk("lives", 32'(lives), 32'(m_lives));
            chk("level", 32'(level), 32'(m_level));
            chk("level_up", 32'(level_up), 32'(m_level_up));
            chk("game_over", 32'(game_over), 32'(m_go));
            chk("endgame", 32'(endgame), 32'(m_eg));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("overrun", 32'(overrun), 32'(m_overrun));
            if (crushed === 1'b1) n_crush++;
            if (level_up === 1'b1) n_lvlup++;
        end
    end

    task automatic clear_cars();
        for (int i = 0; i < NC; i++) begin
            m_cx[i] = 0; m_cy[i] = 0; m_len[i] = 0; m_act[i] = 0;
        end
    endtask

    task automatic set_car(input int i, input int x, input int y, input int len);
        m_cx[i] = x; m_cy[i] = y; m_len[i] = len; m_act[i] = 1;
    endtask

    task automatic do_reset();
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
    endtask

    task automatic frame(input int hx, input int hy);
        int n;
        human_x = 8'(hx);
        human_y = 7'(hy);
        @(negedge clock) frame_tick = 1'b1;
        @(negedge clock) frame_tick = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("scan_timeout", 32'(n), 32'(0));
        @(negedge clock);
    endtask

    initial begin
        int lat, c0;
        clear_cars();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        cmp_en = 1;
        chk("reset_lives", 32'(lives), 32'd3);
        chk("reset_busy", 32'(busy), 32'd0);

        // first-hit latency
        set_car(3, 40, 27, 8);
        human_x = 8'd44; human_y = 7'd28;
        @(negedge clock) frame_tick = 1'b1;
        @(negedge clock) frame_tick = 1'b0;
        lat = 0;
        while (crushed !== 1'b1 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        chk("latency", 32'(lat), 32'd14);
        chk("hit_index3", 32'(hit_index), 32'd3);
        chk("lives_after_hit", 32'(lives), 32'd2);
        @(negedge clock);

        // touching edge, then one pixel of overlap
        do_reset();
        c0 = n_crush;
        frame(48, 28);
        chk("touch_no_hit", 32'(n_crush - c0), 32'd0);
        frame(47, 28);
        chk("overlap_hit", 32'(n_crush - c0), 32'd1);

        // grace window and game over
        do_reset();
        c0 = n_crush;
        for (int f = 1; f <= 60; f++) frame(44, 28);
        chk("grace_one_hit", 32'(n_crush - c0), 32'd1);
        frame(44, 28);
        chk("grace_expired", 32'(n_crush - c0), 32'd2);
        chk("lives_1", 32'(lives), 32'd1);
        for (int f = 1; f <= 60; f++) frame(44, 28);
        chk("third_hit", 32'(n_crush - c0), 32'd3);
        chk("game_over_set", 32'(game_over), 32'd1);
        frame(44, 28);
        chk("frozen_lives", 32'(lives), 32'd0);
        chk("frozen_busy", 32'(busy), 32'd0);
        do_reset();
        chk("restore_lives", 32'(lives), 32'd3);
        chk("restore_go", 32'(game_over), 32'd0);

        // slot filtering: inactive, zero length, lowest hitting index wins
        clear_cars();
        set_car(0, 60, 50, 8); m_act[0] = 0;
        set_car(1, 60, 50, 0);
        set_car(2, 61, 49, 3);
        set_car(5, 59, 51, 4);
        frame(62, 50);
        chk("lowest_index", 32'(hit_index), 32'd2);

        // far-right edge with no wrap
        do_reset();
        clear_cars();
        set_car(7, 250, 10, 20);
        frame(255, 10);
        chk("edge_no_wrap", 32'(hit_index), 32'd7);

        // goal progression
        do_reset();
        clear_cars();
        c0 = n_lvlup;
        frame(133, 102);
        chk("level_up_pulse", 32'(n_lvlup - c0), 32'd1);
        chk("level_1", 32'(level), 32'd1);
        frame(133, 21);
        chk("endgame_set", 32'(endgame), 32'd1);

        // hit has priority over goal on the last level
        do_reset();
        frame(133, 102);
        set_car(0, 130, 19, 8);
        c0 = n_crush;
        frame(133, 21);
        chk("goal_hit_crush", 32'(n_crush - c0), 32'd1);
        chk("goal_hit_no_end", 32'(endgame), 32'd0);

        // overrun does not disturb the running scan
        do_reset();
        clear_cars();
        set_car(3, 40, 27, 8);
        human_x = 8'd44; human_y = 7'd28;
        c0 = n_crush;
        @(negedge clock) frame_tick = 1'b1;
        @(negedge clock) frame_tick = 1'b0;
        repeat (4) @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock) frame_tick = 1'b0;
        repeat (20) @(negedge clock);
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("overrun_one_hit", 32'(n_crush - c0), 32'd1);

        // reset mid-scan discards the partial scan
        do_reset();
        c0 = n_crush;
        @(negedge clock) frame_tick = 1'b1;
        @(negedge clock) frame_tick = 1'b0;
        repeat (5) @(negedge clock);
        chk("midscan_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock) reset = 1'b0;
        chk("reset_idle", 32'(busy), 32'd0);
        repeat (20) @(negedge clock);
        chk("reset_no_crush", 32'(n_crush - c0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/collision_scanner.md
Name: collision_scanner

Overview:
- Parametrised, time-multiplexed collision and progress checker for the street-crossing game.
- Once per video frame it snapshots the player position and scans NUM_CARS vehicle bounding boxes, one per cycle, using true box-overlap tests.
- Manages lives, post-hit grace frames, level advance and win/lose terminal states.
- Sits between the object-position datapath and the game control FSM / renderer.

Parameters:
NUM_CARS, 12, number of vehicle slots scanned per frame (1..64)
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
LEN_W, 5, vehicle length field width
CAR_H, 5, vehicle height in pixels (all cars)
HUMAN_W, 2, player box width
HUMAN_H, 2, player box height
LIVES, 3, lives at reset
GRACE_FRAMES, 60, frames of hit immunity after a hit
LEVELS, 2, number of levels; last level completion = win
GOAL_X, 133, goal x; GOAL_Y_EVEN, 102, goal y on even levels; GOAL_Y_ODD, 21, goal y on odd levels

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  scans start only when high
frame_tick  in  1  one-cycle pulse per frame; starts a scan
human_x  in  X_W  player left edge
human_y  in  Y_W  player top edge
car_x  in  NUM_CARS*X_W  packed car left edges, slot i at [i*X_W +: X_W]
car_y  in  NUM_CARS*Y_W  packed car top edges
car_len  in  NUM_CARS*LEN_W  packed car lengths (0 = slot ignored)
car_active  in  NUM_CARS  per-slot valid mask
crushed  out  1  one-cycle pulse on a counted hit
hit_index  out  clog2(NUM_CARS)  slot of lowest-index hit, held until next counted hit
lives  out  clog2(LIVES+1)  remaining lives
level  out  clog2(LEVELS)  current level
level_up  out  1  one-cycle pulse on level advance
game_over  out  1  sticky: lives reached 0
endgame  out  1  sticky: goal reached on last level
busy  out  1  scan in progress
overrun  out  1  sticky: frame_tick arrived while busy

Behaviour:
- Reset values: crushed=0, hit_index=0, lives=LIVES, level=0, level_up=0, game_over=0, endgame=0, busy=0, overrun=0. Internal grace counter=0, FSM=IDLE.
- Reset is synchronous and has priority over all other activity, including mid-scan; a partial scan is discarded.
- FSM states:
  - IDLE: on frame_tick && enable && !game_over && !endgame, go to SNAP. frame_tick without these conditions is ignored, but the grace counter still decrements (see below).
  - SNAP: one cycle. Latch human_x/human_y, clear hit flag, idx=0, go to SCAN.
  - SCAN: one slot per cycle, idx 0..NUM_CARS-1. Car inputs are sampled live; the source holds them stable for the frame. After the last slot, go to RESOLVE.
  - RESOLVE: one cycle, apply results, return to IDLE.
- busy=1 in SNAP, SCAN and RESOLVE.
- Latency: frame_tick in cycle T gives crushed / level_up / terminal flags registered at the end of cycle T+NUM_CARS+2.
- Overlap test: hit when car_active[i] && car_len[i]!=0 && hx<cx+len && cx<hx+HUMAN_W && hy<cy+CAR_H && cy<hy+HUMAN_H.
  - Compute all sums at X_W+1 / Y_W+1 bits so edge positions near max do not wrap.
  - Touching edges do not hit.
- The first hitting slot (lowest idx) is recorded; later hits in the same scan set no new index.
- RESOLVE priority: hit > goal.
  - Hit with grace==0: lives-=1, crushed pulse, hit_index updated, grace=GRACE_FRAMES. If lives becomes 0, set game_over.
  - Hit with grace!=0: ignored, no pulse.
  - No hit and snapshot equals the goal for the current level (GOAL_X plus GOAL_Y_EVEN/ODD chosen by level parity):
    - if level<LEVELS-1: level+=1, level_up pulse;
    - otherwise set endgame.
- Grace counter decrements by 1 on every frame_tick while nonzero, saturates at 0, and counts even when disabled.
- overrun is set if frame_tick is seen while busy; the extra tick does not start a scan.
- game_over and endgame are mutually exclusive; once set, they freeze lives, level and scanning until reset.

Test Plan:
- Reset, NUM_CARS=12, car 3 at (40,27) len 8, human (44,28), frame_tick -> crushed pulses exactly 14 cycles after the tick, hit_index=3, lives=2.
- Human (48,28) vs car x=40 len 8 (touching edge) -> no crushed; human (47,28) -> crushed.
- Overlapping hit held across frames -> only one crushed within 60 ticks; pulse recurs on the 61st frame, lives 3→2→1.
- Three counted hits -> lives=0, game_over=1; further frame_ticks leave busy=0 and lives=0; reset restores lives=3, game_over=0.
- Human at (133,102), level 0, no cars -> level_up pulse, level=1; then (133,21) -> endgame=1. Same position with a simultaneous hit -> crushed only, no endgame.
- frame_tick pulsed again 5 cycles into a scan -> overrun=1, scan result unaffected; reset mid-scan -> busy=0 next cycle, no crushed.
